// File: rtl/fa_bist_checker.sv
// BIST sweep controller for an external single-bit full adder: walks all 8 {a,b,c} vectors and checks sum/carry.
// Optional build macro FA_BIST_SELFTEST_EN adds inject_fault, which corrupts the golden carry at vector 7.
module fa_bist_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef FA_BIST_SELFTEST_EN
    input  logic       inject_fault,
`endif
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       sum,
    input  logic       carry,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       exp_sum;
    logic       exp_carry;
    logic       mismatch;
    logic [3:0] err_next;

`ifdef FA_BIST_SELFTEST_EN
    logic       fault_lat;
`else
    localparam logic fault_lat = 1'b0;
`endif

    function automatic logic golden_sum(input logic [2:0] v);
        return v[2] ^ v[1] ^ v[0];
    endfunction

    function automatic logic golden_carry(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    // Golden compare against the vector currently on the adder inputs
    always_comb begin
        exp_sum   = golden_sum({a, b, c});
        exp_carry = golden_carry({a, b, c});
        if (fault_lat && (idx == 3'd7))
            exp_carry = 1'b0;
        mismatch  = (sum != exp_sum) || (carry != exp_carry);
        err_next  = err_count + {3'b000, mismatch};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= 3'd0;
            cnt              <= 4'd0;
            {a, b, c}        <= 3'b000;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 4'd0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
`ifdef FA_BIST_SELFTEST_EN
            fault_lat        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state            <= RUN;
                        idx              <= 3'd0;
                        cnt              <= 4'd0;
                        {a, b, c}        <= 3'b000;
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        err_count        <= 4'd0;
                        first_fail_vec   <= 3'd0;
                        first_fail_valid <= 1'b0;
`ifdef FA_BIST_SELFTEST_EN
                        fault_lat        <= inject_fault;
`endif
                    end
                end
                RUN: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt       <= 4'd0;
                        err_count <= err_next;
                        if (mismatch && !first_fail_valid) begin
                            first_fail_vec   <= idx;
                            first_fail_valid <= 1'b1;
                        end
                        // Last vector: report and park the adder inputs at zero
                        if (idx == 3'd7) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            pass      <= (err_next == 4'd0);
                            {a, b, c} <= 3'b000;
                        end else begin
                            idx       <= idx + 3'd1;
                            {a, b, c} <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fa_bist_checker.sv
// Scoreboard bench for fa_bist_checker: two instances (SETTLE_CYCLES 2 and 0) each beside a modelled full adder.
module tb_fa_bist_checker;

    typedef struct {
        int cyc;
        bit pass;
        int err;
        bit ffv;
        int vec;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start2, start0, inj;
    int   mode2, mode0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t q2[$];
    exp_t q0[$];

    logic       a2, b2, c2, sum2, carry2, busy2, done2, pass2, ffv2;
    logic [3:0] err2;
    logic [2:0] ffvec2;
    logic       a0, b0, c0, sum0, carry0, busy0, done0, pass0, ffv0;
    logic [3:0] err0;
    logic [2:0] ffvec0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Adder models: 0 correct, 1 sum stuck at 0, 2 carry replaced by a&b
    assign sum2   = (mode2 == 1) ? 1'b0 : (a2 ^ b2 ^ c2);
    assign carry2 = (mode2 == 2) ? (a2 & b2) : ((a2 & b2) | (a2 & c2) | (b2 & c2));
    assign sum0   = (mode0 == 1) ? 1'b0 : (a0 ^ b0 ^ c0);
    assign carry0 = (mode0 == 2) ? (a0 & b0) : ((a0 & b0) | (a0 & c0) | (b0 & c0));

    fa_bist_checker #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
`ifdef FA_BIST_SELFTEST_EN
        .inject_fault(inj),
`endif
        .a(a2), .b(b2), .c(c2), .sum(sum2), .carry(carry2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_vec(ffvec2), .first_fail_valid(ffv2)
    );

    fa_bist_checker #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
`ifdef FA_BIST_SELFTEST_EN
        .inject_fault(1'b0),
`endif
        .a(a0), .b(b0), .c(c0), .sum(sum0), .carry(carry0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffvec0), .first_fail_valid(ffv0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e, input logic p, input logic [3:0] er,
                                input logic v, input logic [2:0] vec);
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
        chk({tag, "_pass"}, 32'(p), 32'(e.pass));
        chk({tag, "_err_count"}, 32'(er), 32'(e.err));
        chk({tag, "_ffv"}, 32'(v), 32'(e.ffv));
        if (e.ffv) chk({tag, "_ffvec"}, 32'(vec), 32'(e.vec));
    endtask

    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            if (q2.size() == 0) chk("dut2_unexpected_done", 32'(done2), 32'd0);
            else check_result("dut2", q2.pop_front(), pass2, err2, ffv2, ffvec2);
        end
        if (done0 === 1'b1) begin
            if (q0.size() == 0) chk("dut0_unexpected_done", 32'(done0), 32'd0);
            else check_result("dut0", q0.pop_front(), pass0, err0, ffv0, ffvec0);
        end
    end

    task automatic wait_queues(input int budget);
        for (int i = 0; i < budget && (q2.size() != 0 || q0.size() != 0); i++)
            @(negedge clk);
        @(posedge clk);
        chk("dut2_done_timeout", 32'(q2.size()), 32'd0);
        chk("dut0_done_timeout", 32'(q0.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic sweep2(input int mode, input bit p, input int er, input bit v, input int vec,
                          input bit walk);
        exp_t e;
        mode2 = mode;
        e.cyc = cyc + 1 + 24; e.pass = p; e.err = er; e.ffv = v; e.vec = vec;
        q2.push_back(e);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        if (walk) begin
            for (int k = 1; k <= 24; k++) begin
                chk("walk_abc", 32'({a2, b2, c2}), 32'((k - 1) / 3));
                chk("walk_busy", 32'(busy2), 32'd1);
                @(negedge clk);
            end
        end
        wait_queues(60);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; start2 = 1'b0; start0 = 1'b0; inj = 1'b0; mode2 = 0; mode0 = 0;
        repeat (3) @(negedge clk);
        chk("reset_dut2", 32'({a2, b2, c2, busy2, done2, pass2, err2, ffvec2, ffv2}), 32'd0);
        chk("reset_dut0", 32'({a0, b0, c0, busy0, done0, pass0, err0, ffvec0, ffv0}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Correct adder with vector walk, then results must hold
        sweep2(0, 1'b1, 0, 1'b0, 0, 1'b1);
        repeat (5) @(negedge clk);
        chk("hold_pass", 32'(pass2), 32'd1);
        chk("hold_abc_idle", 32'({a2, b2, c2, busy2}), 32'd0);

        sweep2(1, 1'b0, 4, 1'b1, 3'b001, 1'b0);
        sweep2(2, 1'b0, 2, 1'b1, 3'b011, 1'b0);
        repeat (4) @(negedge clk);
        chk("hold_err", 32'(err2), 32'd2);

        // start re-asserted mid-sweep is ignored; rst aborts with no done
        mode2 = 1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (8) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_abc_no_restart", 32'({a2, b2, c2}), 32'd4);
        chk("abort_err_midsweep", 32'(err2), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_reset_outs", 32'({a2, b2, c2, busy2, done2, pass2, err2, ffvec2, ffv2}), 32'd0);
        repeat (30) @(negedge clk);
        chk("abort_still_idle", 32'({busy2, err2}), 32'd0);
        sweep2(0, 1'b1, 0, 1'b0, 0, 1'b0);

        // SETTLE_CYCLES=0: single sweep, then start held for back-to-back sweeps
        mode0 = 0;
        e.cyc = cyc + 9; e.pass = 1'b1; e.err = 0; e.ffv = 1'b0; e.vec = 0;
        q0.push_back(e);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_queues(30);
        e.cyc = cyc + 9; q0.push_back(e);
        e.cyc = cyc + 19; q0.push_back(e);
        start0 = 1'b1;
        repeat (12) @(negedge clk);
        start0 = 1'b0;
        wait_queues(30);
        mode0 = 2;
        e.cyc = cyc + 9; e.pass = 1'b0; e.err = 2; e.ffv = 1'b1; e.vec = 3;
        q0.push_back(e);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_queues(30);

`ifdef FA_BIST_SELFTEST_EN
        inj = 1'b1;
        sweep2(0, 1'b0, 1, 1'b1, 3'b111, 1'b0);
        inj = 1'b0;
        sweep2(0, 1'b1, 0, 1'b0, 0, 1'b0);
`endif

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
